// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-back, write-allocate.
// Misses are serviced word by word over a req/ack backing-memory port.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module mem_stage_dcache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - OFF - IDX;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WB     = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;

    logic [OFF-1:0]   word_sel;
    logic [IDX-1:0]   index;
    logic [TAG_W-1:0] tag_in;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES*WORDS_PER_LINE];

    logic [1:0]     state;
    logic [OFF-1:0] cnt;

    logic access;
    logic tag_match;
    logic in_idle;
    logic miss;
    logic last_word;
    logic ack_now;
    logic unused;

    assign word_sel = addr[2 +: OFF];
    assign index    = addr[2+OFF +: IDX];
    assign tag_in   = addr[31 -: TAG_W];
    // Byte offset is meaningless for a word-aligned cache
    assign unused   = &{1'b0, addr[1:0]};

    assign access    = memRead | memWrite;
    assign tag_match = valid[index] && (tags[index] == tag_in);
    assign in_idle   = (state == S_IDLE);
    assign hit       = in_idle & (~access | tag_match);
    assign miss      = in_idle & access & ~tag_match;
    assign last_word = (cnt == {OFF{1'b1}});
    // Acks that arrive with no outstanding request are dropped here
    assign ack_now   = mem_req & mem_ack;

    // Load data is returned straight from the array on a hit; stores win over loads
    always_comb begin
        readData = '0;
        if (hit && memRead && !memWrite)
            readData = data[{index, word_sel}];
    end

    // Miss FSM, line state bits and the registered backing-memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        cnt   <= '0;
                        state <= (valid[index] && dirty[index]) ? S_WB : S_REFILL;
                    end else if (hit && memWrite) begin
                        dirty[index] <= 1'b1;
                    end
                end
                S_WB, S_REFILL: begin
                    if (!mem_req) begin
                        // Issue the word for cnt; it is held until acked
                        mem_req <= 1'b1;
                        if (state == S_WB) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tags[index], index, cnt, 2'b00};
                            mem_wdata <= data[{index, cnt}];
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= {tag_in, index, cnt, 2'b00};
                            mem_wdata <= '0;
                        end
                    end else if (mem_ack) begin
                        // Drop req for one cycle between words
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        if (last_word) begin
                            if (state == S_WB) begin
                                state <= S_REFILL;
                            end else begin
                                state        <= S_IDLE;
                                valid[index] <= 1'b1;
                                dirty[index] <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays: refill words land on ack, store hits write one word
    always_ff @(posedge clk) begin
        if (state == S_REFILL && ack_now) begin
            data[{index, cnt}] <= mem_rdata;
            if (last_word)
                tags[index] <= tag_in;
        end else if (hit && memWrite) begin
            data[{index, word_sel}] <= writeData;
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating access statistics: completed accesses and miss entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && access && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (miss && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
